regfile_scoreboard: RTL and testbench

Hazard scoreboard sequencing access to the 32x32 two-write/two-read register file. Tracks outstanding writes per architectural register from issue to writeback and gates instruction issue when a source operand or destination would be unsafe. Accounts for the register file's same-cycle write-to-read bypass, so an operand whose last pending write lands this cycle does not stall. Sits between decode/issue and the register file read stage.

---
 rtl/regfile_scoreboard.sv | 109 ++++++++++
 tb/tb_regfile_scoreboard.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_scoreboard.sv
// Hazard scoreboard for the 2W/2R register file: counts in-flight writes per register.
// Issue gating is combinational and honours the write-to-read bypass; busy is 1 edge after fire.
module regfile_scoreboard #(
  parameter int CNT_W   = 2,
  parameter int STALL_W = 16
) (
  input  logic               clk_in,
  input  logic               rst_in,
  input  logic               flush_in,
  input  logic               issue_valid_in,
  input  logic [4:0]         issue_rd_in,
  input  logic               issue_rd_we_in,
  input  logic [4:0]         issue_rs1_in,
  input  logic               issue_rs1_re_in,
  input  logic [4:0]         issue_rs2_in,
  input  logic               issue_rs2_re_in,
  output logic               issue_ready_out,
  input  logic               wb1_we_in,
  input  logic [4:0]         wb1_addr_in,
  input  logic               wb2_we_in,
  input  logic [4:0]         wb2_addr_in,
  output logic [31:0]        busy_mask_out,
  output logic               err_out,
  output logic [STALL_W-1:0] stall_cnt_out
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] cnt_q  [32];
  logic [CNT_W-1:0] cnt_d  [32];
  logic [CNT_W-1:0] eff_lo [32];
  logic [CNT_W-1:0] rem    [32];
  logic [CNT_W:0]   dec;
  logic [CNT_W:0]   eff;
  logic             err_hit;
  logic             haz_rs1;
  logic             haz_rs2;
  logic             haz_rd;
  logic             fire;
  logic             stall_hit;

  // rem[r] is what is still pending once this cycle's writebacks land (bypass view)
  always_comb begin
    err_hit = 1'b0;
    dec     = '0;
    eff     = '0;
    for (int r = 0; r < 32; r++) begin
      dec = (CNT_W+1)'(wb1_we_in && (wb1_addr_in == 5'(r)) && (r != 0))
          + (CNT_W+1)'(wb2_we_in && (wb2_addr_in == 5'(r)) && (r != 0));
      eff = (dec > {1'b0, cnt_q[r]}) ? {1'b0, cnt_q[r]} : dec;
      if (dec > {1'b0, cnt_q[r]}) begin
        err_hit = 1'b1;
      end
      eff_lo[r] = eff[CNT_W-1:0];
      rem[r]    = cnt_q[r] - eff[CNT_W-1:0];
    end
  end

  assign haz_rs1 = issue_rs1_re_in && (issue_rs1_in != 5'd0) && (rem[issue_rs1_in] != '0);
  assign haz_rs2 = issue_rs2_re_in && (issue_rs2_in != 5'd0) && (rem[issue_rs2_in] != '0);
  // Destination check deliberately uses the pre-writeback count
  assign haz_rd  = issue_rd_we_in && (issue_rd_in != 5'd0) && (cnt_q[issue_rd_in] == CNT_MAX);

  assign issue_ready_out = rst_in && !flush_in && !haz_rs1 && !haz_rs2 && !haz_rd;
  assign fire            = issue_valid_in && issue_ready_out;
  assign stall_hit       = issue_valid_in && !issue_ready_out && !flush_in;

  always_comb begin
    for (int r = 0; r < 32; r++) begin
      cnt_d[r] = cnt_q[r]
               + CNT_W'(fire && issue_rd_we_in && (issue_rd_in == 5'(r)) && (r != 0))
               - eff_lo[r];
    end
  end

  always_comb begin
    busy_mask_out = '0;
    for (int r = 1; r < 32; r++) begin
      busy_mask_out[r] = (cnt_q[r] != '0);
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      for (int r = 0; r < 32; r++) begin
        cnt_q[r] <= '0;
      end
      err_out       <= 1'b0;
      stall_cnt_out <= '0;
    end else begin
      if (flush_in) begin
        for (int r = 0; r < 32; r++) begin
          cnt_q[r] <= '0;
        end
      end else begin
        for (int r = 0; r < 32; r++) begin
          cnt_q[r] <= cnt_d[r];
        end
        if (err_hit) begin
          err_out <= 1'b1;
        end
      end
      if (stall_hit && (stall_cnt_out != '1)) begin
        stall_cnt_out <= stall_cnt_out + STALL_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed bench for regfile_scoreboard with an integer-count reference model checked every cycle.
module tb_regfile_scoreboard;

  localparam int CNT_W   = 2;
  localparam int STALL_W = 16;
  localparam int MAXC    = (1 << CNT_W) - 1;
  localparam int MAXS    = (1 << STALL_W) - 1;

  logic               clk_in = 1'b0;
  logic               rst_in;
  logic               flush_in;
  logic               issue_valid_in;
  logic [4:0]         issue_rd_in;
  logic               issue_rd_we_in;
  logic [4:0]         issue_rs1_in;
  logic               issue_rs1_re_in;
  logic [4:0]         issue_rs2_in;
  logic               issue_rs2_re_in;
  logic               issue_ready_out;
  logic               wb1_we_in;
  logic [4:0]         wb1_addr_in;
  logic               wb2_we_in;
  logic [4:0]         wb2_addr_in;
  logic [31:0]        busy_mask_out;
  logic               err_out;
  logic [STALL_W-1:0] stall_cnt_out;

  regfile_scoreboard #(.CNT_W(CNT_W), .STALL_W(STALL_W)) dut (
    .clk_in          (clk_in),
    .rst_in          (rst_in),
    .flush_in        (flush_in),
    .issue_valid_in  (issue_valid_in),
    .issue_rd_in     (issue_rd_in),
    .issue_rd_we_in  (issue_rd_we_in),
    .issue_rs1_in    (issue_rs1_in),
    .issue_rs1_re_in (issue_rs1_re_in),
    .issue_rs2_in    (issue_rs2_in),
    .issue_rs2_re_in (issue_rs2_re_in),
    .issue_ready_out (issue_ready_out),
    .wb1_we_in       (wb1_we_in),
    .wb1_addr_in     (wb1_addr_in),
    .wb2_we_in       (wb2_we_in),
    .wb2_addr_in     (wb2_addr_in),
    .busy_mask_out   (busy_mask_out),
    .err_out         (err_out),
    .stall_cnt_out   (stall_cnt_out)
  );

  always #5 clk_in = ~clk_in;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: plain integer pending-write counts per register
  int m_cnt [32];
  bit m_err   = 1'b0;
  int m_stall = 0;

  function automatic int m_dec(input int r);
    int d = 0;
    if (r != 0 && wb1_we_in && int'(wb1_addr_in) == r) d++;
    if (r != 0 && wb2_we_in && int'(wb2_addr_in) == r) d++;
    return d;
  endfunction

  function automatic int m_eff(input int r);
    return (m_dec(r) < m_cnt[r]) ? m_dec(r) : m_cnt[r];
  endfunction

  function automatic bit m_ready();
    bit ok = 1'b1;
    int a;
    a = int'(issue_rs1_in);
    if (issue_rs1_re_in && a != 0 && (m_cnt[a] - m_eff(a)) != 0) ok = 1'b0;
    a = int'(issue_rs2_in);
    if (issue_rs2_re_in && a != 0 && (m_cnt[a] - m_eff(a)) != 0) ok = 1'b0;
    a = int'(issue_rd_in);
    if (issue_rd_we_in && a != 0 && m_cnt[a] == MAXC) ok = 1'b0;
    return rst_in && !flush_in && ok;
  endfunction

  function automatic logic [31:0] m_busy();
    logic [31:0] m = '0;
    for (int r = 1; r < 32; r++) m[r] = (m_cnt[r] != 0);
    return m;
  endfunction

  always @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      for (int r = 0; r < 32; r++) m_cnt[r] <= 0;
      m_err   <= 1'b0;
      m_stall <= 0;
    end else begin
      if (flush_in) begin
        for (int r = 0; r < 32; r++) m_cnt[r] <= 0;
      end else begin
        for (int r = 0; r < 32; r++) begin
          m_cnt[r] <= m_cnt[r] - m_eff(r)
                    + ((issue_valid_in && m_ready() && issue_rd_we_in &&
                        int'(issue_rd_in) == r && r != 0) ? 1 : 0);
          if (m_dec(r) > m_cnt[r]) m_err <= 1'b1;
        end
      end
      if (issue_valid_in && !m_ready() && !flush_in && m_stall < MAXS) m_stall <= m_stall + 1;
    end
  end

  always @(negedge clk_in) begin
    check("cyc_ready", {31'd0, issue_ready_out}, {31'd0, m_ready()});
    check("cyc_busy",  busy_mask_out, m_busy());
    check("cyc_err",   {31'd0, err_out}, {31'd0, m_err});
    check("cyc_stall", {16'd0, stall_cnt_out}, 32'(m_stall));
  end

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic set_issue(input logic vld, input logic [4:0] rd, input logic rd_we,
                           input logic [4:0] rs1, input logic rs1_re,
                           input logic [4:0] rs2, input logic rs2_re);
    issue_valid_in  = vld;
    issue_rd_in     = rd;
    issue_rd_we_in  = rd_we;
    issue_rs1_in    = rs1;
    issue_rs1_re_in = rs1_re;
    issue_rs2_in    = rs2;
    issue_rs2_re_in = rs2_re;
  endtask

  task automatic set_wb(input logic w1, input logic [4:0] a1, input logic w2, input logic [4:0] a2);
    wb1_we_in   = w1;
    wb1_addr_in = a1;
    wb2_we_in   = w2;
    wb2_addr_in = a2;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int r = 0; r < 32; r++) m_cnt[r] = 0;
    rst_in   = 1'b0;
    flush_in = 1'b0;
    set_issue(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
    set_wb(1'b0, 5'd0, 1'b0, 5'd0);
    #2;
    check("rst_ready", {31'd0, issue_ready_out}, 32'd0);
    check("rst_busy",  busy_mask_out, 32'd0);
    step(); step();
    rst_in = 1'b1;

    // Reset release, idle
    set_issue(1'b0, 5'd9, 1'b1, 5'd3, 1'b1, 5'd17, 1'b1);
    #1;
    check("t1_ready", {31'd0, issue_ready_out}, 32'd1);
    check("t1_busy",  busy_mask_out, 32'd0);
    check("t1_err",   {31'd0, err_out}, 32'd0);
    check("t1_stall", {16'd0, stall_cnt_out}, 32'd0);
    step();

    // RAW on r5, then bypass
    set_issue(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
    step();
    set_issue(1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 5'd0, 1'b0);
    #1;
    check("t2_busy",  busy_mask_out, 32'h0000_0020);
    check("t2_stall_rdy", {31'd0, issue_ready_out}, 32'd0);
    step();
    check("t2_stall_cnt", {16'd0, stall_cnt_out}, 32'd1);
    set_wb(1'b1, 5'd5, 1'b0, 5'd0);
    #1;
    check("t2_bypass", {31'd0, issue_ready_out}, 32'd1);
    step();
    set_wb(1'b0, 5'd0, 1'b0, 5'd0);
    set_issue(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
    #1;
    check("t2_busy_clr", busy_mask_out, 32'd0);

    // Counter saturation on r7
    set_issue(1'b1, 5'd7, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
    for (int i = 0; i < 3; i++) step();
    #1;
    check("t3_busy",   busy_mask_out, 32'h0000_0080);
    check("t3_full",   {31'd0, issue_ready_out}, 32'd0);
    step();
    set_wb(1'b1, 5'd7, 1'b1, 5'd7);
    #1;
    check("t3_wb_cyc", {31'd0, issue_ready_out}, 32'd0);
    step();
    set_wb(1'b0, 5'd0, 1'b0, 5'd0);
    #1;
    check("t3_busy7",  busy_mask_out, 32'h0000_0080);
    check("t3_ready",  {31'd0, issue_ready_out}, 32'd1);
    check("t3_stall",  {16'd0, stall_cnt_out}, 32'd3);
    step();
    set_issue(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
    set_wb(1'b1, 5'd7, 1'b1, 5'd7);
    step();
    set_wb(1'b0, 5'd0, 1'b0, 5'd0);

    // r0 is never tracked
    set_issue(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      #1;
      check("t4_busy",  busy_mask_out, 32'd0);
      check("t4_ready", {31'd0, issue_ready_out}, 32'd1);
      step();
    end
    set_issue(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);

    // Spurious writeback
    set_wb(1'b1, 5'd9, 1'b0, 5'd0);
    #1;
    check("t5_err_pre", {31'd0, err_out}, 32'd0);
    step();
    set_wb(1'b0, 5'd0, 1'b0, 5'd0);
    #1;
    check("t5_err",  {31'd0, err_out}, 32'd1);
    check("t5_busy", busy_mask_out, 32'd0);
    step();
    check("t5_sticky", {31'd0, err_out}, 32'd1);

    // Flush with colliding issue and writeback
    set_issue(1'b1, 5'd3, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
    step();
    set_issue(1'b1, 5'd4, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
    step();
    #1;
    check("t6_busy34", busy_mask_out, 32'h0000_0018);
    flush_in = 1'b1;
    set_issue(1'b1, 5'd6, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
    set_wb(1'b1, 5'd3, 1'b0, 5'd0);
    #1;
    check("t6_flush_rdy", {31'd0, issue_ready_out}, 32'd0);
    step();
    flush_in = 1'b0;
    set_issue(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
    set_wb(1'b0, 5'd0, 1'b0, 5'd0);
    #1;
    check("t6_busy_clr", busy_mask_out, 32'd0);
    check("t6_stall",    {16'd0, stall_cnt_out}, 32'd3);

    // Async reset in the middle of a stall
    set_issue(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
    step();
    set_issue(1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 5'd0, 1'b0);
    step();
    check("t6_pre_rst", {16'd0, stall_cnt_out}, 32'd4);
    #1;
    rst_in = 1'b0;
    #1;
    check("ar_busy",  busy_mask_out, 32'd0);
    check("ar_ready", {31'd0, issue_ready_out}, 32'd0);
    check("ar_err",   {31'd0, err_out}, 32'd0);
    check("ar_stall", {16'd0, stall_cnt_out}, 32'd0);
    step();
    set_issue(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
    rst_in = 1'b1;
    step(); step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
